store_narrow_unit: RTL

Multicycle store-path formatter for the MIPS multicycle CPU. It is the narrowing counterpart to immediate/load extension: it takes a 32-bit register value and a store size (word, half or byte) and produces a word-aligned memory write. The write carries lane-replicated data and byte enables. The unit runs a req/ack handshake with data memory, flags misaligned addresses and ack timeouts, and sits between the datapath's MEM stage and the data RAM.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/store_lane_fmt.sv | 48 ++++
 rtl/store_narrow_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the store path: store sizes, FSM states and
//            error causes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;
    localparam logic [1:0] ST_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/store_lane_fmt.sv
// ============================================================================
// Module   : store_lane_fmt
// Brief    : Combinational narrowing of a register value into lane-replicated
//            write data, byte enables and an alignment fault flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_fmt
    import cpu_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [1:0]  StSel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_fmt,
    output logic [3:0]  be,
    output logic        fault
);

    logic [1:0] lane;
    logic       half;

    always_comb begin
        lane      = (BIG_ENDIAN != 0) ? (2'd3 - addr_lo) : addr_lo;
        half      = addr_lo[1] ^ (BIG_ENDIAN != 0);
        wdata_fmt = wdata;
        be        = 4'b1111;
        fault     = 1'b0;
        case (StSel)
            ST_WORD: fault = (addr_lo != 2'b00);
            ST_HALF: begin
                wdata_fmt = {2{wdata[15:0]}};
                be        = half ? 4'b1100 : 4'b0011;
                fault     = addr_lo[0];
            end
            ST_BYTE: begin
                wdata_fmt = {4{wdata[7:0]}};
                be        = 4'b0001 << lane;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/store_narrow_unit.sv
// ============================================================================
// Module   : store_narrow_unit
// Brief    : Multicycle store formatter with req/ack memory handshake,
//            misalignment detection and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_narrow_unit
    import cpu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int BIG_ENDIAN  = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  StSel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [1:0]  err_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        fmt_fault;

    store_lane_fmt #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_fmt (
        .StSel     (StSel),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .wdata_fmt (fmt_wdata),
        .be        (fmt_be),
        .fault     (fmt_fault)
    );

    // Pulse outputs are set on the transition into DONE/ERR so they are
    // registered Moore outputs of those states.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= CAUSE_NONE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= CAUSE_NONE;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (fmt_fault) begin
                            state_q <= S_ERR;
                            err_q   <= CAUSE_MISALIGN;
                        end else begin
                            state_q     <= S_REQ;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_wdata_q <= fmt_wdata;
                            mem_be_q    <= fmt_be;
                            cnt_q       <= 8'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if ((cnt_q + 8'd1) == 8'(ACK_TIMEOUT)) begin
                            state_q   <= S_ERR;
                            mem_req_q <= 1'b0;
                            err_q     <= CAUSE_TIMEOUT;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = (err_q == CAUSE_MISALIGN);
    assign timeout   = (err_q == CAUSE_TIMEOUT);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

`default_nettype wire
